// File: rtl/cs_pkg.sv
// Shared constants for the approximate-average filter chain.
// Used by the filter stage and its result buffer.
package cs_pkg;

  localparam int CS_DATA_W = 10;
  localparam int CS_WINDOW = 9;
  localparam int CS_WARMUP = CS_WINDOW - 1;

endpackage

// File: rtl/cs_fifo_core.sv
// First-word-fall-through FIFO core with explicit level tracking.
// Flush empties the queue but leaves stored words in place.
module cs_fifo_core
  import cs_pkg::*;
#(
  parameter int DATA_W = CS_DATA_W,
  parameter int DEPTH  = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [AW:0]       level_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam logic [AW:0]   LVL_ONE  = 1;
  localparam logic [AW:0]   LVL_FULL = DEPTH[AW:0];
  localparam logic [AW-1:0] PTR_ONE  = 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level_q, level_d;
  logic              do_push, do_pop;

  assign full_o  = (level_q == LVL_FULL);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A full FIFO still accepts a write when a pop frees a slot.
  assign do_pop  = pop_i & ~flush_i & ~empty_o;
  assign do_push = push_i & ~flush_i
                 & (~full_o | do_pop);

  // Next-state pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      unique case ({do_push, do_pop})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end
  end

  // Pointer and level registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage; cleared on reset so the head reads zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/cs_result_buffer.sv
// Result buffer behind the averaging filter: drops warm-up results,
// queues the rest and keeps sticky loss statistics.
module cs_result_buffer
  import cs_pkg::*;
#(
  parameter int DATA_W = CS_DATA_W,
  parameter int DEPTH  = 8,
  parameter int WARMUP = CS_WARMUP
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     warm,
  output logic                     overflow,
  output logic [7:0]               drop_cnt
);

  localparam int CW = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);
  localparam logic [CW-1:0] W_MAX  = CW'(WARMUP);
  localparam logic [CW-1:0] W_ONE  = 1;
  localparam logic          W_RST  = (WARMUP == 0);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          warm_q, warm_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    drop_q, drop_d;
  logic          push, pop, full, empty, lost;

  assign push = in_valid & warm_q;
  assign pop  = out_valid & out_ready;
  assign lost = push & full & ~pop & ~flush;

  assign out_valid = ~empty;
  assign warm      = warm_q;
  assign overflow  = ovf_q;
  assign drop_cnt  = drop_q;

  cs_fifo_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (in_data),
    .rdata_o (out_data),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );

  // Warm-up count saturates at WARMUP; flush restarts it.
  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (in_valid && cnt_q < W_MAX) begin
      cnt_d = cnt_q + W_ONE;
    end
    warm_d = (cnt_d == W_MAX);
  end

  // Loss statistics survive flush; only reset clears them.
  always_comb begin
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (lost) begin
      ovf_d = 1'b1;
      if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end
  end

  // Control and statistics registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      warm_q <= W_RST;
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      warm_q <= warm_d;
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
    end
  end

endmodule

// File: tb/tb_cs_result_buffer.sv
// Scoreboard bench for cs_result_buffer: directed stimulus queues
// expected outputs, a negedge monitor checks every handshake.
module tb_cs_result_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic       in_valid;
  logic [9:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_data;
  logic [3:0] level;
  logic       warm;
  logic       overflow;
  logic [7:0] drop_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int sb[$];

  always #5 clk = ~clk;

  cs_result_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .warm      (warm),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int d, input bit expect_out);
    in_valid = 1'b1;
    in_data  = 10'(d);
    if (expect_out) sb.push_back(d);
    step();
    in_valid = 1'b0;
  endtask

  // Handshake completes at the next posedge; inputs are stable then.
  always @(negedge clk) begin
    if (!reset && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL pop_unexpected: got %0d want none", out_data);
      end else begin
        chk("pop_data", int'(out_data), sb.pop_front());
      end
    end
  end

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    step();
    step();
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_warm", int'(warm), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_drop", int'(drop_cnt), 0);
    chk("rst_data", int'(out_data), 0);
    reset = 1'b0;
    step();

    // Warm-up: 1..8 discarded, 9..12 pass with one-cycle latency.
    out_ready = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      chk("warm_before", int'(warm), (i > 8) ? 1 : 0);
      strobe(i, i >= 9);
      if (i >= 9) begin
        chk("lat_valid", int'(out_valid), 1);
        chk("lat_data", int'(out_data), i);
      end else begin
        chk("wu_valid", int'(out_valid), 0);
      end
    end
    step();
    chk("wu_ovf", int'(overflow), 0);
    chk("wu_level", int'(level), 0);

    // Overflow: 100..107 stored, 108 and 109 lost.
    out_ready = 1'b0;
    for (int v = 100; v <= 109; v++) strobe(v, v <= 107);
    chk("ovf_level", int'(level), 8);
    chk("ovf_flag", int'(overflow), 1);
    chk("ovf_drop", int'(drop_cnt), 2);
    out_ready = 1'b1;
    repeat (8) step();
    chk("ovf_drain_valid", int'(out_valid), 0);

    // Full with simultaneous push and pop.
    out_ready = 1'b0;
    for (int v = 200; v <= 207; v++) strobe(v, 1'b1);
    chk("fp_level0", int'(level), 8);
    out_ready = 1'b1;
    strobe(208, 1'b1);
    chk("fp_level1", int'(level), 8);
    chk("fp_drop", int'(drop_cnt), 2);
    chk("fp_ovf", int'(overflow), 1);
    repeat (8) step();
    chk("fp_drain_level", int'(level), 0);

    // Flush with concurrent strobe.
    out_ready = 1'b0;
    for (int v = 1; v <= 3; v++) strobe(v, 1'b1);
    chk("fl_level0", int'(level), 3);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 10'd50;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    chk("fl_level", int'(level), 0);
    chk("fl_valid", int'(out_valid), 0);
    chk("fl_warm", int'(warm), 0);
    chk("fl_ovf", int'(overflow), 1);
    chk("fl_drop", int'(drop_cnt), 2);
    out_ready = 1'b1;
    for (int v = 60; v <= 67; v++) strobe(v, 1'b0);
    chk("fl_wu_level", int'(level), 0);
    chk("fl_wu_warm", int'(warm), 1);
    strobe(70, 1'b1);
    chk("fl_first", int'(out_data), 70);
    step();

    // Asynchronous reset between edges.
    out_ready = 1'b0;
    for (int v = 80; v <= 84; v++) strobe(v, 1'b1);
    chk("ar_level0", int'(level), 5);
    chk("ar_valid0", int'(out_valid), 1);
    #3;
    reset = 1'b1;
    #1;
    sb.delete();
    chk("ar_valid", int'(out_valid), 0);
    chk("ar_level", int'(level), 0);
    chk("ar_warm", int'(warm), 0);
    chk("ar_ovf", int'(overflow), 0);
    chk("ar_drop", int'(drop_cnt), 0);
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    for (int v = 90; v <= 97; v++) strobe(v, 1'b0);
    chk("ar_wu_level", int'(level), 0);
    strobe(98, 1'b1);
    chk("ar_first", int'(out_data), 98);
    step();

    // Drop counter saturation.
    out_ready = 1'b0;
    for (int v = 400; v <= 407; v++) strobe(v, 1'b1);
    for (int i = 0; i < 300; i++) strobe(1023, 1'b0);
    chk("sat_drop", int'(drop_cnt), 255);
    chk("sat_ovf", int'(overflow), 1);
    chk("sat_level", int'(level), 8);
    chk("sat_head", int'(out_data), 400);
    out_ready = 1'b1;
    repeat (8) step();
    chk("sat_drain", int'(out_valid), 0);
    chk("sat_hold", int'(drop_cnt), 255);
    step();

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
